axi_stream_sequence_checker: RTL and testbench
==============================================

// Module: axi_stream_sequence_checker
// PURPOSE
//  Single-stream sink that consumes an AXI-Stream fed by axi_stream_counter -> axi_stream_random_stall.
//  Checks each accepted beat against an internally generated incrementing sequence.
//  Reports transfer, mismatch and watchdog statistics, and applies its own random backpressure via block.
//  It is the one-stream counterpart to the two-stream comparator for stall-stage benches and on-board self-test.
// PARAMETERS
//  DATA_BITS      32  tdata width; the expected sequence wraps modulo 2**DATA_BITS
//  COUNT_BITS     32  width of transfer_count and mismatch_count
//  START_VALUE    0   expected tdata of the first beat after reset
//  TIMEOUT_CYCLES 256 consecutive no-transfer cycles (RUN/FAULT) that raise timeout; 0 = watchdog off
// PORTS
//  clk               in   1           clock; all logic on posedge
//  rst               in   1           synchronous reset, active-low (0 = reset)
//  in_tvalid         in   1           stream valid
//  in_tready         out  1           stream ready
//  in_tdata          in   DATA_BITS   stream data
//  block             in   1           1 = deassert in_tready this cycle (random backpressure)
//  transfer          out  1           registered pulse: a beat was accepted last cycle
//  transfer_count    out  COUNT_BITS  accepted beats, saturating
//  mismatch          out  1           registered pulse: last accepted beat != expected
//  mismatch_latch    out  1           sticky OR of mismatch
//  mismatch_count    out  COUNT_BITS  mismatching beats, saturating
//  mismatch_got      out  DATA_BITS   tdata of FIRST mismatching beat
//  mismatch_expected out  DATA_BITS   expected value at FIRST mismatch
//  timeout           out  1           sticky watchdog flag
// BEHAVIOUR
//  - Handshake: in_tready = rst && !block, combinational with no dependence on in_tvalid; accept = in_tvalid && in_tready.
//  - Reset (rst==0 at posedge): state=ARMED, expected=START_VALUE, all counters/flags/captures=0.
//    in_tready=0 while rst==0. A reset mid-stream discards the in-flight beat; nothing is accepted that cycle.
//  - Status latency: transfer, mismatch and counts update at the posedge after accept (1 cycle).
//  - FSM (state_t): ARMED -> RUN on first accept; RUN -> FAULT on any mismatching accept.
//    FAULT is sticky until reset.
//  - Every accept: compare in_tdata to expected; expected <= expected+1 (wraps 2**DATA_BITS-1 -> 0).
//  - First mismatch only (mismatch_latch was 0): capture mismatch_got/mismatch_expected; later mismatches do not overwrite.
//  - Counters saturate at all-ones; no wrap.
//  - Watchdog: idle counter clears on accept. Otherwise in RUN/FAULT it increments, saturating at TIMEOUT_CYCLES.
//    timeout sets when idle reaches TIMEOUT_CYCLES. Inactive in ARMED, so startup latency is never flagged.
//    Stalls caused by block count as idle.
//  - Simultaneous accept and idle==TIMEOUT_CYCLES-1: accept wins; the counter clears and timeout is not set.
// CONFIGURATION
//  AXI_SEQ_CHECK_RESYNC_EN defined: on a mismatch, expected <= in_tdata+1, so one dropped/duplicated beat
//    counts as exactly 1 mismatch.
//  Not defined: expected always advances by 1 regardless of data, so a drop typically makes every subsequent beat mismatch.
//  State transitions and captures are identical in both builds.
// STRUCTURE
//  Shared package axi_stream_test_pkg: typedef enum logic [1:0] {ARMED, RUN, FAULT} state_t.
//  The same package holds a saturate-compare helper function.
//  Sub-module: sat_counter #(WIDTH, MAX), instantiated for transfer_count, mismatch_count and the idle counter.
//  sat_counter has inc and clr inputs; clr wins over inc.
// TESTING
//  1 Counter source, block=0, 100 beats 0..99 -> transfer_count=100, mismatch_latch=0, timeout=0.
//  2 DATA_BITS=8, START_VALUE=250, 10 beats 250..255,0..3 -> wrap accepted, no mismatch.
//  3 Beats 0,1,2,4,5,6:
//    RESYNC_EN -> mismatch_count=1, got=4, expected=3.
//    Not defined -> mismatch_count=3, got=4, expected=3.
//    Both builds end in FAULT.
//  4 TIMEOUT_CYCLES=16, one beat then in_tvalid=0 -> timeout sets after 16 cycles.
//    Beat at idle=15 -> timeout stays 0.
//  5 block=1 for 20 cycles with in_tvalid=1 -> in_tready=0, no transfer.
//    With TIMEOUT_CYCLES=16 and state RUN -> timeout=1.
//  6 rst=0 for 1 cycle after 50 beats, source restarts at 0 -> all counts=0, state ARMED, no mismatch.
//  Random: 25% stall upstream, 25% block, 10000 cycles -> >=100 transfers, mismatch_latch=0.

Source files
------------

// File: rtl/axi_stream_test_pkg.sv
// axi_stream_test_pkg: checker state type and saturation helper shared by the stream test blocks.
package axi_stream_test_pkg;

    typedef enum logic [1:0] {ARMED, RUN, FAULT} state_t;

    function automatic logic sat_hit(input logic [63:0] value, input logic [63:0] limit);
        return value >= limit;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at MAX; clr has priority over inc.
module sat_counter
    import axi_stream_test_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb count_d = clr ? '0 : (inc && !sat_hit(64'(count_q), 64'(MAX))) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/axi_stream_sequence_checker.sv
// axi_stream_sequence_checker: AXI-Stream sink checking every beat against an incrementing sequence.
// Define AXI_SEQ_CHECK_RESYNC_EN to resync the expected value to the received data after a mismatch.
module axi_stream_sequence_checker
    import axi_stream_test_pkg::*;
#(
    parameter int                   DATA_BITS      = 32,
    parameter int                   COUNT_BITS     = 32,
    parameter logic [DATA_BITS-1:0] START_VALUE    = '0,
    parameter int                   TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic [DATA_BITS-1:0]  in_tdata,
    input  logic                  block,
    output logic                  transfer,
    output logic [COUNT_BITS-1:0] transfer_count,
    output logic                  mismatch,
    output logic                  mismatch_latch,
    output logic [COUNT_BITS-1:0] mismatch_count,
    output logic [DATA_BITS-1:0]  mismatch_got,
    output logic [DATA_BITS-1:0]  mismatch_expected,
    output logic                  timeout
);

    localparam int IDLE_BITS = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                 state_q;
    logic [DATA_BITS-1:0]   expected_q, expected_d;
    logic [DATA_BITS-1:0]   got_q, exp_cap_q;
    logic                   transfer_q, mismatch_q, latch_q, timeout_q;
    logic                   accept, miss, idle_inc;
    logic [IDLE_BITS-1:0]   idle_count;

    assign in_tready = rst && !block;
    assign accept    = in_tvalid && in_tready;
    assign miss      = accept && (in_tdata != expected_q);
    // The watchdog stays quiet until the first beat so startup latency is never flagged.
    assign idle_inc  = (TIMEOUT_CYCLES != 0) && !accept && (state_q != ARMED);

`ifdef AXI_SEQ_CHECK_RESYNC_EN
    assign expected_d = !accept ? expected_q : miss ? in_tdata + 1'b1 : expected_q + 1'b1;
`else
    assign expected_d = accept ? expected_q + 1'b1 : expected_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARMED;
            expected_q <= START_VALUE;
            transfer_q <= 1'b0;
            mismatch_q <= 1'b0;
            latch_q    <= 1'b0;
            got_q      <= '0;
            exp_cap_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (accept && state_q != FAULT) state_q <= miss ? FAULT : RUN;
            expected_q <= expected_d;
            transfer_q <= accept;
            mismatch_q <= miss;
            latch_q    <= latch_q || miss;
            if (miss && !latch_q) begin
                got_q     <= in_tdata;
                exp_cap_q <= expected_q;
            end
            timeout_q  <= timeout_q || (idle_inc && sat_hit(64'(idle_count) + 64'd1, 64'(TIMEOUT_CYCLES)));
        end
    end

    sat_counter #(.WIDTH(COUNT_BITS)) u_transfer_cnt (
        .clk(clk), .rst(rst), .inc(accept), .clr(1'b0), .count(transfer_count)
    );

    sat_counter #(.WIDTH(COUNT_BITS)) u_mismatch_cnt (
        .clk(clk), .rst(rst), .inc(miss), .clr(1'b0), .count(mismatch_count)
    );

    sat_counter #(.WIDTH(IDLE_BITS), .MAX(IDLE_BITS'(TIMEOUT_CYCLES))) u_idle_cnt (
        .clk(clk), .rst(rst), .inc(idle_inc), .clr(accept), .count(idle_count)
    );

    assign transfer          = transfer_q;
    assign mismatch          = mismatch_q;
    assign mismatch_latch    = latch_q;
    assign mismatch_got      = got_q;
    assign mismatch_expected = exp_cap_q;
    assign timeout           = timeout_q;

endmodule

// File: tb/tb_axi_stream_sequence_checker.sv
// tb_axi_stream_sequence_checker: table vectors, directed corner sequences and a random run against a reference model.
module tb_axi_stream_sequence_checker;

    localparam int         TO    = 16;
    localparam int         START = 250;

`ifdef AXI_SEQ_CHECK_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, in_tvalid, in_tready, block;
    logic [7:0] in_tdata;
    logic       transfer, mismatch, mismatch_latch, timeout;
    logic [7:0] transfer_count, mismatch_count, mismatch_got, mismatch_expected;

    always #5 clk = ~clk;

    axi_stream_sequence_checker #(
        .DATA_BITS(8), .COUNT_BITS(8), .START_VALUE(8'd250), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .block(block), .transfer(transfer), .transfer_count(transfer_count), .mismatch(mismatch),
        .mismatch_latch(mismatch_latch), .mismatch_count(mismatch_count), .mismatch_got(mismatch_got),
        .mismatch_expected(mismatch_expected), .timeout(timeout)
    );

    int checks = 0;
    int failures = 0;

    int m_exp, m_tc, m_mc, m_idle, m_got, m_gexp;
    bit m_started, m_tr, m_mm, m_latch, m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Behavioural model: sequence numbers, saturating counts and idle run length as plain integers.
    function automatic void model(input bit r, input bit v, input bit b, input int d);
        if (!r) begin
            m_exp = START; m_tc = 0; m_mc = 0; m_idle = 0; m_got = 0; m_gexp = 0;
            m_started = 0; m_tr = 0; m_mm = 0; m_latch = 0; m_to = 0;
        end else if (v && !b) begin
            m_tr = 1;
            m_mm = (d != m_exp);
            if (m_tc < 255) m_tc++;
            if (m_mm) begin
                if (m_mc < 255) m_mc++;
                if (!m_latch) begin m_got = d; m_gexp = m_exp; end
                m_latch = 1;
            end
            m_exp = (((RESYNC && m_mm) ? d : m_exp) + 1) % 256;
            m_started = 1;
            m_idle = 0;
        end else begin
            m_tr = 0;
            m_mm = 0;
            if (m_started) begin
                if (m_idle < TO) m_idle++;
                if (m_idle == TO) m_to = 1;
            end
        end
    endfunction

    task automatic step(input bit r, input bit v, input bit b, input logic [7:0] d);
        rst = r; in_tvalid = v; block = b; in_tdata = d;
        #1 chk("tready", in_tready, r && !b);
        @(posedge clk);
        model(r, v, b, d);
        #1;
        chk("transfer", transfer, m_tr);
        chk("mismatch", mismatch, m_mm);
        chk("transfer_count", transfer_count, m_tc);
        chk("mismatch_count", mismatch_count, m_mc);
        chk("mismatch_latch", mismatch_latch, m_latch);
        chk("mismatch_got", mismatch_got, m_got);
        chk("mismatch_expected", mismatch_expected, m_gexp);
        chk("timeout", timeout, m_to);
    endtask

    task automatic beats(input int n, input int first);
        for (int i = 0; i < n; i++) step(1, 1, 0, 8'(first + i));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 8'd0);
    endtask

    typedef struct {
        bit r, v, b;
        logic [7:0] d;
        bit rdy, tr, mm;
    } vec_t;

    vec_t tbl[8];
    logic [7:0] cur_d;
    bit cur_v, blk;
    int n_acc;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'd250, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 8'd251, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'd251, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 8'd251, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 8'd7,   1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 8'd253, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 8'd250, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].d);
            chk("tbl_tready", in_tready, tbl[i].rdy);
            chk("tbl_transfer", transfer, tbl[i].tr);
            chk("tbl_mismatch", mismatch, tbl[i].mm);
        end
        // 100 in-order beats that wrap 255 -> 0 along the way.
        step(0, 0, 0, 8'd0);
        chk("reset_count", transfer_count, 0);
        chk("reset_timeout", timeout, 0);
        beats(100, START);
        chk("t1_count", transfer_count, 100);
        chk("t1_latch", mismatch_latch, 0);
        chk("t1_timeout", timeout, 0);
        // One skipped beat.
        step(0, 0, 0, 8'd0);
        beats(3, 250);
        beats(3, 254);
        chk("t3_mcount", mismatch_count, RESYNC ? 1 : 3);
        chk("t3_got", mismatch_got, 254);
        chk("t3_expected", mismatch_expected, 253);
        // Watchdog boundary.
        step(0, 0, 0, 8'd0);
        beats(1, 250);
        idle(15);
        chk("t4_before", timeout, 0);
        idle(1);
        chk("t4_after", timeout, 1);
        step(0, 0, 0, 8'd0);
        beats(1, 250);
        idle(15);
        beats(1, 251);
        chk("t4_accept_wins", timeout, 0);
        idle(15);
        chk("t4_rearm_before", timeout, 0);
        idle(1);
        chk("t4_rearm_after", timeout, 1);
        // Backpressure stall counts as idle.
        step(0, 0, 0, 8'd0);
        beats(1, 250);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 8'd251);
        chk("t5_tready", in_tready, 0);
        chk("t5_count", transfer_count, 1);
        chk("t5_timeout", timeout, 1);
        // Mid-stream reset, restart from the start value.
        step(0, 0, 0, 8'd0);
        beats(50, START);
        step(0, 1, 0, 8'(START + 50));
        chk("t6_count", transfer_count, 0);
        chk("t6_latch", mismatch_latch, 0);
        idle(30);
        chk("t6_armed_timeout", timeout, 0);
        beats(10, START);
        chk("t6_count2", transfer_count, 10);
        chk("t6_mcount", mismatch_count, 0);
        // Random upstream stalls and backpressure.
        step(0, 0, 0, 8'd0);
        cur_d = 8'(START);
        cur_v = 0;
        n_acc = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!cur_v) cur_v = $urandom_range(0, 3) != 0;
            blk = $urandom_range(0, 3) == 0;
            step(1, cur_v, blk, cur_d);
            if (cur_v && !blk) begin
                cur_d++;
                cur_v = 0;
                n_acc++;
            end
        end
        chk("rand_enough", 32'(n_acc >= 100), 1);
        chk("rand_latch", mismatch_latch, 0);
        chk("rand_count_sat", transfer_count, 255);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
